fifo_serial_tx: RTL and testbench



---
 rtl/fifo_serial_pkg.sv | 17 +
 rtl/serial_bit_timer.sv | 30 +++
 rtl/fifo_serial_tx.sv | 120 ++++++++++++
 tb/tb_fifo_serial_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_serial_pkg.sv
// Shared types and constants for the FIFO-fed serial transmitter and its
// future receive-side companion.
package fifo_serial_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 1 + DATA_W;  // start bit plus data bits

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LATCH,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/serial_bit_timer.sv
// Free-running bit-period counter: tick is high in the last clock of each
// serial bit; clear holds the count at zero so a new state starts a fresh bit.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // With CLKS_PER_BIT=1 the count never leaves zero, so tick is constant high.
  assign tick = (count == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops bytes from the FIFO read port and sends each one as a serial frame:
// start bit, 8 data bits LSB first, STOP_BITS stop bits. All outputs are flops.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              rn,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int STOP_CYCLES = STOP_BITS * CLKS_PER_BIT;
  localparam int SW          = $clog2(STOP_CYCLES + 1);
  localparam logic [SW-1:0] STOP_LOAD = SW'(STOP_CYCLES - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(FRAME_BITS - 2);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [2:0]        bit_idx;
  logic              stop_cnt;
  logic [SW-1:0]     stop_left;
  logic              tick;
  logic              timer_clear;

  // The timer only runs in the timed states; holding it cleared elsewhere
  // guarantees START begins at count zero, and later entries land on a wrap.
  assign timer_clear = (state == IDLE) || (state == REQ) || (state == LATCH);

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .tick   (tick)
  );

  // stop_left counts down the stop phase so the registered frame_done can be
  // raised one edge early and land exactly on the final stop cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      stop_left  <= '0;
      rn         <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !empty) begin
            state <= REQ;
            rn    <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          state <= LATCH;
          rn    <= 1'b0;
        end
        LATCH: begin
          shift   <= fifo_data;
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= START;
        end
        START: begin
          if (tick) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              tx         <= 1'b1;
              stop_cnt   <= 1'b0;
              stop_left  <= STOP_LOAD;
              frame_done <= (STOP_CYCLES == 1);
              state      <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end
        end
        STOP: begin
          if (stop_left != '0) begin
            stop_left <= stop_left - 1'b1;
          end
          frame_done <= (stop_left == SW'(1));
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              busy       <= 1'b0;
              frame_done <= 1'b0;
              state      <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: two instances (C=4,S=1 and C=1,S=2) fed by queue
// FIFOs, compared every cycle against a frame-timing model derived from t0.
module tb_fifo_serial_tx;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       empty0, empty1;
  logic [7:0] fdata0, fdata1;
  logic       rn0, rn1, tx0, tx1, busy0, busy1, fd0, fd1;

  always #5 clock = ~clock;

  fifo_serial_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .empty(empty0),
    .fifo_data(fdata0), .rn(rn0), .tx(tx0), .busy(busy0), .frame_done(fd0)
  );

  fifo_serial_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut_c1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .empty(empty1),
    .fifo_data(fdata1), .rn(rn1), .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic [7:0] exp_q[$];
  bit         m_active[2];
  int         m_t0[2];
  int         m_starts[2];
  int         rn_cnt[2];
  logic [7:0] m_byte[2];
  logic [7:0] dec[2];

  function automatic int cpb(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int stp(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int flen(input int d);
    return 3 + (9 + stp(d)) * cpb(d);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Expected outputs follow directly from the frame start cycle t0.
  task automatic check_dut(input int d);
    int   k = 0;
    int   c;
    int   b;
    logic etx, ern, ebusy, efd;
    logic atx, arn, abusy, afd;
    atx   = d ? tx1 : tx0;
    arn   = d ? rn1 : rn0;
    abusy = d ? busy1 : busy0;
    afd   = d ? fd1 : fd0;
    c     = cpb(d);
    if (m_active[d] && (cyc - m_t0[d] >= flen(d))) m_active[d] = 1'b0;
    etx = 1'b1; ern = 1'b0; ebusy = 1'b0; efd = 1'b0;
    if (m_active[d]) begin
      k     = cyc - m_t0[d];
      ebusy = 1'b1;
      ern   = (k == 1);
      if (k >= 3 && k < 3 + c) begin
        etx = 1'b0;
      end else if (k >= 3 + c && k < 3 + 9 * c) begin
        b   = (k - 3 - c) / c;
        etx = m_byte[d][b];
        if ((k - 3 - c) % c == c / 2) dec[d][b] = atx;
      end
      efd = (k == flen(d) - 1);
    end
    check($sformatf("tx%0d", d), atx, etx);
    check($sformatf("rn%0d", d), arn, ern);
    check($sformatf("busy%0d", d), abusy, ebusy);
    check($sformatf("frame_done%0d", d), afd, efd);
    if (m_active[d] && k == flen(d) - 1) begin
      if (d == 0) begin
        if (exp_q.size() != 0) check("byte0", dec[0], exp_q.pop_front());
      end else begin
        check("byte1", dec[1], m_byte[1]);
      end
    end
  endtask

  task automatic decide();
    for (int d = 0; d < 2; d++) begin
      logic e;
      e = d ? empty1 : empty0;
      if (reset_n && enable && !e && !m_active[d]) begin
        m_active[d] = 1'b1;
        m_t0[d]     = cyc;
        m_starts[d]++;
        dec[d]      = 8'h00;
        m_byte[d]   = d ? fq1[0] : fq0[0];
        if (d == 0) exp_q.push_back(fq0[0]);
      end
    end
  endtask

  task automatic service();
    if (rn0) begin
      rn_cnt[0]++;
      if (fq0.size() != 0) fdata0 = fq0.pop_front();
      empty0 = (fq0.size() == 0);
    end
    if (rn1) begin
      rn_cnt[1]++;
      if (fq1.size() != 0) fdata1 = fq1.pop_front();
      empty1 = (fq1.size() == 0);
    end
  endtask

  task automatic push(input int d, input logic [7:0] v);
    if (d == 0) begin fq0.push_back(v); empty0 = 1'b0; end
    else begin fq1.push_back(v); empty1 = 1'b0; end
  endtask

  task automatic cycle();
    decide();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    check_dut(0);
    check_dut(1);
    service();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Called just after a negedge: reset lands well before the next posedge.
  task automatic async_reset(input int hold);
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx0", tx0, 1'b1);
    check("rst_rn0", rn0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_fd0", fd0, 1'b0);
    check("rst_tx1", tx1, 1'b1);
    check("rst_busy1", busy1, 1'b0);
    m_active[0] = 1'b0;
    m_active[1] = 1'b0;
    exp_q.delete();
    run(hold);
    reset_n = 1'b1;
  endtask

  task automatic wait_model_k(input string tag, input int k_target);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      if (m_active[0] && (cyc - m_t0[0] == k_target)) found = 1'b1;
    end
    check(tag, found, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0;
    empty0 = 1'b1; empty1 = 1'b1; fdata0 = 8'h00; fdata1 = 8'h00;
    run(3);
    reset_n = 1'b1;
    run(3);
    async_reset(2);
    run(2);

    // Single byte 0xA5
    push(0, 8'hA5);
    enable = 1'b1;
    run(50);

    // Back-to-back 0x01, 0xFF
    push(0, 8'h01);
    push(0, 8'hFF);
    run(2 * 43 + 10);
    check("fifo0_drained", fq0.size(), 0);
    check("rn_count_b2b", rn_cnt[0], m_starts[0]);

    // Empty with enable high, then data with enable low
    run(100);
    enable = 1'b0;
    push(0, 8'h96);
    run(20);
    check("no_rn_disabled", fq0.size(), 1);

    // Enable dropped during DATA: current frame completes, no new frame
    enable = 1'b1;
    wait_model_k("reach_data", 3 + 4 + 8);
    enable = 1'b0;
    push(0, 8'h5A);
    push(0, 8'hC3);
    run(60);
    check("held_bytes", fq0.size(), 2);

    // Reset during data bit 3: 0x5A is lost, 0xC3 follows
    enable = 1'b1;
    wait_model_k("reach_bit3", 3 + 4 + 3 * 4 + 1);
    async_reset(3);
    run(60);
    check("fifo0_after_reset", fq0.size(), 0);
    enable = 1'b0;
    run(5);

    // C=1, S=2 corner with 0x3C
    push(1, 8'h3C);
    enable = 1'b1;
    run(25);
    check("fifo1_drained", fq1.size(), 0);

    // Random traffic on both instances
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0 && fq0.size() < 8) push(0, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0 && fq1.size() < 8) push(1, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      cycle();
    end
    enable = 1'b0;
    run(60);
    check("rn_count0", rn_cnt[0], m_starts[0]);
    check("rn_count1", rn_cnt[1], m_starts[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
